// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX issue stage: ALU control codes,
// RV32I opcodes and the funct3 values the decoder distinguishes.
package id_ex_stage_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SGE  = 4'b1010;
    localparam logic [3:0] ALU_SGEU = 4'b1011;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_JMP  = 4'b1110;
    localparam logic [3:0] ALU_ERR  = 4'b1111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_SR   = 3'b101;

endpackage

// File: rtl/id_ex_stage_alu_ctrl_dec.sv
// Combinational ALU control decode from {opcode, funct3, funct7b5}.
// Unknown opcodes and reserved branch funct3 values decode to ERR.
module alu_ctrl_dec
    import id_ex_stage_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] control,
    output logic       illegal
);

    always_comb begin
        control = ALU_ERR;
        illegal = 1'b0;
        unique case (1'b1)
            opcode == OPC_OP: control = {funct7b5, funct3};
            // only shifts look at instr[30]; ADDI with a negative imm stays ADD
            opcode == OPC_OPIMM: control = {(funct3 == F3_SR) & funct7b5, funct3};
            opcode == OPC_BRANCH: begin
                unique case (funct3)
                    F3_BEQ, F3_BNE: control = ALU_SUB;
                    F3_BLT:         control = ALU_SLT;
                    F3_BGE:         control = ALU_SGE;
                    F3_BLTU:        control = ALU_SLTU;
                    F3_BGEU:        control = ALU_SGEU;
                    default: begin
                        control = ALU_ERR;
                        illegal = 1'b1;
                    end
                endcase
            end
            opcode == OPC_LOAD, opcode == OPC_STORE,
            opcode == OPC_LUI, opcode == OPC_AUIPC: control = ALU_ADD;
            opcode == OPC_JAL, opcode == OPC_JALR: control = ALU_JMP;
            default: begin
                control = ALU_ERR;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, ALU control
// generation and load-use hazard detection.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int REG_ADDR = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [WIDTH-1:0]    id_pc,
    input  logic [WIDTH-1:0]    id_rs1_data,
    input  logic [WIDTH-1:0]    id_rs2_data,
    input  logic [WIDTH-1:0]    id_imm,
    input  logic [REG_ADDR-1:0] id_rs1,
    input  logic [REG_ADDR-1:0] id_rs2,
    input  logic [REG_ADDR-1:0] id_rd,
    input  logic [6:0]          id_opcode,
    input  logic [2:0]          id_funct3,
    input  logic                id_funct7b5,
    input  logic                ex_stall,
    input  logic                ex_flush,
    input  logic [REG_ADDR-1:0] exm_rd,
    input  logic                exm_wen,
    input  logic [WIDTH-1:0]    exm_data,
    input  logic [REG_ADDR-1:0] wb_rd,
    input  logic                wb_wen,
    input  logic [WIDTH-1:0]    wb_data,
    output logic                hazard_stall,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    output logic [3:0]          alu_control,
    output logic [WIDTH-1:0]    store_data,
    output logic                ex_valid,
    output logic [REG_ADDR-1:0] ex_rd,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic                ex_branch,
    output logic                ex_illegal
);

    logic [3:0]          dec_control;
    logic                dec_illegal;
    logic                dec_reg_write;
    logic                dec_mem_read;
    logic                dec_mem_write;
    logic                dec_branch;
    logic                dec_a_pc;
    logic                dec_a_zero;
    logic                dec_b_rs2;
    logic                uses_rs1;
    logic                uses_rs2;

    logic [WIDTH-1:0]    ex_pc;
    logic [WIDTH-1:0]    ex_rs1_data;
    logic [WIDTH-1:0]    ex_rs2_data;
    logic [WIDTH-1:0]    ex_imm;
    logic [REG_ADDR-1:0] ex_rs1;
    logic [REG_ADDR-1:0] ex_rs2;
    logic                ex_a_pc;
    logic                ex_a_zero;
    logic                ex_b_rs2;
    logic [WIDTH-1:0]    rs1_fwd;
    logic [WIDTH-1:0]    rs2_fwd;
    logic                rs_match;

    alu_ctrl_dec u_dec (
        .opcode   (id_opcode),
        .funct3   (id_funct3),
        .funct7b5 (id_funct7b5),
        .control  (dec_control),
        .illegal  (dec_illegal)
    );

    always_comb begin
        dec_mem_read  = id_opcode == OPC_LOAD;
        dec_mem_write = id_opcode == OPC_STORE;
        dec_branch    = id_opcode == OPC_BRANCH;
        dec_reg_write = (id_opcode == OPC_OP) || (id_opcode == OPC_OPIMM) ||
                        (id_opcode == OPC_LOAD) || (id_opcode == OPC_LUI) ||
                        (id_opcode == OPC_AUIPC) || (id_opcode == OPC_JAL) ||
                        (id_opcode == OPC_JALR);
        dec_a_pc      = (id_opcode == OPC_AUIPC) || (id_opcode == OPC_JAL);
        dec_a_zero    = id_opcode == OPC_LUI;
        dec_b_rs2     = (id_opcode == OPC_OP) || (id_opcode == OPC_BRANCH);
        uses_rs2      = (id_opcode == OPC_OP) || (id_opcode == OPC_STORE) ||
                        (id_opcode == OPC_BRANCH);
        uses_rs1      = uses_rs2 || (id_opcode == OPC_OPIMM) ||
                        (id_opcode == OPC_LOAD) || (id_opcode == OPC_JALR);
    end

    assign rs_match = (uses_rs1 && id_rs1 == ex_rd) ||
                      (uses_rs2 && id_rs2 == ex_rd);

    assign hazard_stall = ex_valid && ex_mem_read && (ex_rd != '0) &&
                          id_valid && rs_match && !ex_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_illegal   <= 1'b0;
            alu_control  <= ALU_ADD;
            ex_a_pc      <= 1'b0;
            ex_a_zero    <= 1'b0;
            ex_b_rs2     <= 1'b0;
            ex_pc        <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_imm       <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
        end else if (ex_flush || (!ex_stall && hazard_stall)) begin
            // bubble: kill the slot, leave the datapath fields as they were
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_illegal   <= 1'b0;
            alu_control  <= ALU_ADD;
        end else if (!ex_stall) begin
            ex_valid     <= id_valid;
            ex_rd        <= id_rd;
            ex_reg_write <= id_valid && dec_reg_write;
            ex_mem_read  <= id_valid && dec_mem_read;
            ex_mem_write <= id_valid && dec_mem_write;
            ex_branch    <= id_valid && dec_branch;
            ex_illegal   <= id_valid && dec_illegal;
            alu_control  <= dec_control;
            ex_a_pc      <= dec_a_pc;
            ex_a_zero    <= dec_a_zero;
            ex_b_rs2     <= dec_b_rs2;
            ex_pc        <= id_pc;
            ex_rs1_data  <= id_rs1_data;
            ex_rs2_data  <= id_rs2_data;
            ex_imm       <= id_imm;
            ex_rs1       <= id_rs1;
            ex_rs2       <= id_rs2;
        end
    end

    assign rs1_fwd = (exm_wen && exm_rd == ex_rs1 && ex_rs1 != '0) ? exm_data :
                     (wb_wen && wb_rd == ex_rs1 && ex_rs1 != '0)   ? wb_data :
                     ex_rs1_data;
    assign rs2_fwd = (exm_wen && exm_rd == ex_rs2 && ex_rs2 != '0) ? exm_data :
                     (wb_wen && wb_rd == ex_rs2 && ex_rs2 != '0)   ? wb_data :
                     ex_rs2_data;

    assign alu_a      = ex_a_pc ? ex_pc : (ex_a_zero ? '0 : rs1_fwd);
    assign alu_b      = ex_b_rs2 ? rs2_fwd : ex_imm;
    assign store_data = rs2_fwd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, forwarding, hazards,
// stall/flush priority and asynchronous reset.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic        id_funct7b5;
    logic        ex_stall, ex_flush;
    logic [4:0]  exm_rd, wb_rd;
    logic        exm_wen, wb_wen;
    logic [31:0] exm_data, wb_data;
    logic        hazard_stall;
    logic [31:0] alu_a, alu_b, store_data;
    logic [3:0]  alu_control;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic        ex_branch, ex_illegal;
    logic [4:0]  ex_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_opcode(id_opcode), .id_funct3(id_funct3),
        .id_funct7b5(id_funct7b5), .ex_stall(ex_stall), .ex_flush(ex_flush),
        .exm_rd(exm_rd), .exm_wen(exm_wen), .exm_data(exm_data),
        .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_data(wb_data),
        .hazard_stall(hazard_stall), .alu_a(alu_a), .alu_b(alu_b),
        .alu_control(alu_control), .store_data(store_data),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_branch(ex_branch), .ex_illegal(ex_illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [31:0] d1, input logic [31:0] d2,
                             input logic [31:0] imm, input logic [31:0] pc);
        id_valid = 1'b1;
        id_opcode = op; id_funct3 = f3; id_funct7b5 = f7;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_pc = pc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 ||
            ex_illegal !== 1'b0 || ex_rd !== 5'd0) begin
            errors++;
            $display("FAIL reset_ctrl got v=%b rw=%b il=%b rd=%0d exp 0",
                     ex_valid, ex_reg_write, ex_illegal, ex_rd);
        end
        checks++;
        if (alu_control !== 4'b0000 || alu_a !== 32'd0) begin
            errors++;
            $display("FAIL reset_alu got ctl=%b a=%h exp 0000/0",
                     alu_control, alu_a);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_op_sub();
        set_instr(7'b0110011, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3,
                  32'd7, 32'd5, 32'd0, 32'h40);
        step();
        checks++;
        if (alu_control !== 4'b1000) begin
            errors++;
            $display("FAIL sub_ctl got %b exp 1000", alu_control);
        end
        checks++;
        if (alu_a !== 32'd7 || alu_b !== 32'd5) begin
            errors++;
            $display("FAIL sub_ops got a=%h b=%h exp 7/5", alu_a, alu_b);
        end
        checks++;
        if (ex_reg_write !== 1'b1 || ex_valid !== 1'b1 || ex_rd !== 5'd3) begin
            errors++;
            $display("FAIL sub_ctrl got rw=%b v=%b rd=%0d exp 1/1/3",
                     ex_reg_write, ex_valid, ex_rd);
        end
    endtask

    task automatic test_opimm();
        set_instr(7'b0010011, 3'b000, 1'b1, 5'd1, 5'd0, 5'd2,
                  32'd9, 32'd0, 32'hffff_ffff, 32'h44);
        step();
        checks++;
        if (alu_control !== 4'b0000 || alu_b !== 32'hffff_ffff) begin
            errors++;
            $display("FAIL addi_neg got ctl=%b b=%h exp 0000/ffffffff",
                     alu_control, alu_b);
        end
        set_instr(7'b0010011, 3'b101, 1'b1, 5'd1, 5'd0, 5'd2,
                  32'd9, 32'd0, 32'h0000_0403, 32'h48);
        step();
        checks++;
        if (alu_control !== 4'b1101) begin
            errors++;
            $display("FAIL srai got %b exp 1101", alu_control);
        end
    endtask

    task automatic test_forwarding();
        set_instr(7'b0010011, 3'b000, 1'b0, 5'd1, 5'd0, 5'd6,
                  32'h11, 32'd0, 32'd4, 32'h50);
        step();
        exm_rd = 5'd1; exm_wen = 1'b1; exm_data = 32'hAA;
        wb_rd = 5'd1; wb_wen = 1'b1; wb_data = 32'hBB;
        #1;
        checks++;
        if (alu_a !== 32'hAA) begin
            errors++;
            $display("FAIL fwd_exm got %h exp 000000aa", alu_a);
        end
        exm_wen = 1'b0;
        #1;
        checks++;
        if (alu_a !== 32'hBB) begin
            errors++;
            $display("FAIL fwd_wb got %h exp 000000bb", alu_a);
        end
        exm_wen = 1'b0; wb_wen = 1'b0;
        set_instr(7'b0010011, 3'b000, 1'b0, 5'd0, 5'd0, 5'd6,
                  32'd0, 32'd0, 32'd4, 32'h54);
        step();
        exm_rd = 5'd0; exm_wen = 1'b1;
        wb_rd = 5'd0; wb_wen = 1'b1;
        #1;
        checks++;
        if (alu_a !== 32'd0 || alu_b !== 32'd4) begin
            errors++;
            $display("FAIL fwd_x0 got a=%h b=%h exp 0/4", alu_a, alu_b);
        end
        exm_wen = 1'b0; wb_wen = 1'b0;
    endtask

    task automatic test_load_use();
        set_instr(7'b0000011, 3'b010, 1'b0, 5'd1, 5'd0, 5'd4,
                  32'h100, 32'd0, 32'd8, 32'h60);
        step();
        set_instr(7'b0110011, 3'b000, 1'b0, 5'd4, 5'd1, 5'd5,
                  32'h3, 32'h2, 32'd0, 32'h64);
        ex_flush = 1'b1;
        #1;
        checks++;
        if (hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL hz_flush got %b exp 0", hazard_stall);
        end
        ex_flush = 1'b0;
        #1;
        checks++;
        if (hazard_stall !== 1'b1 || ex_mem_read !== 1'b1) begin
            errors++;
            $display("FAIL hz_detect got hz=%b mr=%b exp 1/1",
                     hazard_stall, ex_mem_read);
        end
        step();
        checks++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 ||
            hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL hz_bubble got v=%b rw=%b hz=%b exp 0/0/0",
                     ex_valid, ex_reg_write, hazard_stall);
        end
        step();
        checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd5 || ex_reg_write !== 1'b1 ||
            alu_a !== 32'h3 || alu_b !== 32'h2) begin
            errors++;
            $display("FAIL hz_issue got v=%b rd=%0d rw=%b a=%h b=%h exp 1/5/1/3/2",
                     ex_valid, ex_rd, ex_reg_write, alu_a, alu_b);
        end
    endtask

    task automatic test_flush_stall();
        set_instr(7'b0100011, 3'b010, 1'b0, 5'd2, 5'd3, 5'd0,
                  32'h200, 32'h77, 32'd12, 32'h70);
        ex_flush = 1'b1; ex_stall = 1'b1;
        step();
        ex_flush = 1'b0; ex_stall = 1'b0;
        checks++;
        if (ex_valid !== 1'b0 || ex_mem_write !== 1'b0) begin
            errors++;
            $display("FAIL flush_wins got v=%b mw=%b exp 0/0",
                     ex_valid, ex_mem_write);
        end
        set_instr(7'b0110011, 3'b100, 1'b0, 5'd1, 5'd2, 5'd7,
                  32'h30, 32'h0F, 32'd0, 32'h74);
        step();
        ex_stall = 1'b1;
        set_instr(7'b0000011, 3'b010, 1'b0, 5'd9, 5'd0, 5'd9,
                  32'h5, 32'h6, 32'd1, 32'h78);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (ex_rd !== 5'd7 || alu_control !== 4'b0100 ||
                alu_a !== 32'h30 || alu_b !== 32'h0F || ex_mem_read !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d got rd=%0d ctl=%b a=%h b=%h exp 7/0100/30/0f",
                         i, ex_rd, alu_control, alu_a, alu_b);
            end
        end
        ex_stall = 1'b0;
    endtask

    task automatic test_store_branch();
        set_instr(7'b0100011, 3'b010, 1'b0, 5'd2, 5'd3, 5'd0,
                  32'h200, 32'h77, 32'd12, 32'h80);
        step();
        checks++;
        if (ex_mem_write !== 1'b1 || ex_reg_write !== 1'b0 ||
            store_data !== 32'h77 || alu_b !== 32'd12 || alu_control !== 4'b0000) begin
            errors++;
            $display("FAIL store got mw=%b rw=%b sd=%h b=%h ctl=%b exp 1/0/77/c/0000",
                     ex_mem_write, ex_reg_write, store_data, alu_b, alu_control);
        end
        set_instr(7'b1100011, 3'b111, 1'b0, 5'd2, 5'd3, 5'd0,
                  32'h1, 32'h2, 32'd16, 32'h84);
        step();
        checks++;
        if (alu_control !== 4'b1011 || ex_branch !== 1'b1 || alu_b !== 32'h2) begin
            errors++;
            $display("FAIL bgeu got ctl=%b br=%b b=%h exp 1011/1/2",
                     alu_control, ex_branch, alu_b);
        end
    endtask

    task automatic test_illegal_jump();
        set_instr(7'b1111111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3,
                  32'h1, 32'h2, 32'd0, 32'h90);
        step();
        checks++;
        if (alu_control !== 4'b1111 || ex_illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal got ctl=%b il=%b exp 1111/1",
                     alu_control, ex_illegal);
        end
        set_instr(7'b1101111, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1,
                  32'h0, 32'h0, 32'd8, 32'h100);
        step();
        checks++;
        if (alu_control !== 4'b1110 || alu_a !== 32'h100 ||
            ex_reg_write !== 1'b1 || ex_illegal !== 1'b0) begin
            errors++;
            $display("FAIL jal got ctl=%b a=%h rw=%b il=%b exp 1110/100/1/0",
                     alu_control, alu_a, ex_reg_write, ex_illegal);
        end
    endtask

    task automatic test_mid_reset();
        set_instr(7'b0110011, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3,
                  32'd7, 32'd5, 32'd0, 32'hA0);
        ex_stall = 1'b0;
        step();
        ex_stall = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 ||
            alu_control !== 4'b0000 || ex_rd !== 5'd0) begin
            errors++;
            $display("FAIL async_rst got v=%b rw=%b ctl=%b rd=%0d exp 0/0/0000/0",
                     ex_valid, ex_reg_write, alu_control, ex_rd);
        end
        #1;
        rst = 1'b0;
        ex_stall = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 1'b0;
        id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_opcode = '0; id_funct3 = '0; id_funct7b5 = 1'b0;
        ex_stall = 1'b0; ex_flush = 1'b0;
        exm_rd = '0; exm_wen = 1'b0; exm_data = '0;
        wb_rd = '0; wb_wen = 1'b0; wb_data = '0;
        test_reset();
        test_op_sub();
        test_opimm();
        test_forwarding();
        test_load_use();
        test_flush_stall();
        test_store_branch();
        test_illegal_jump();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
